regbank_arbiter: RTL
====================

Name: regbank_arbiter

Overview:
- Round-robin arbiter that shares one 8-entry x 8-bit register bank among N_REQ requesters.
- Each requester raises req and receives a registered gnt. While it holds gnt it performs one read or write per cycle.
- A hold limit forces re-arbitration so no requester can monopolise the bank.
- Sits between CPU/peripheral masters and the shared general-purpose register bank; all register contents are also exported for datapath use.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 3, register address width; the bank has 2**ADDR_W entries.
- MAX_HOLD, 4, maximum consecutive accesses per grant while other requests are pending (1..15).

Ports:
- clock  in  1  system clock, rising-edge.
- reset_N  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester access request.
- we  in  N_REQ  per-requester write enable; 1 = write, 0 = read.
- addr  in  N_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*8  packed write data; requester i uses slice [i*8 +: 8].
- gnt  out  N_REQ  one-hot-or-zero grant, registered.
- rdata  out  8  read data from the last read access.
- rvalid  out  1  one-cycle pulse: rdata updated by the read on the previous edge.
- busy  out  1  high while any gnt is high.
- regs_q  out  8*2**ADDR_W  all bank registers; entry k is at [k*8 +: 8].

Behaviour:
- Reset (async, reset_N=0) clears immediately:
  - gnt=0, rdata=8'h00, rvalid=0, busy=0.
  - All bank entries = 8'h00.
  - Round-robin pointer ptr=0, hold counter hcnt=0, state IDLE.
- States:
  - IDLE: no owner.
  - OWN: owner index own is valid; gnt[own]=1.
- Grant latency: a req first sampled high at edge n in IDLE gives gnt high after edge n, i.e. one cycle.
- Selection: the first set bit of req scanning ptr, ptr+1, ... wrapping modulo N_REQ. On every new grant, ptr <= winner+1 (mod N_REQ).
- Access rule:
  - An access occurs at each edge where state=OWN and req[own]=1.
  - Write: bank[addr_own] <= wdata_own.
  - Read: rdata <= bank[addr_own] and rvalid <= 1. rvalid returns to 0 on the next edge unless another read occurs.
  - Only one access can occur per cycle, so there is no read/write conflict.
  - Non-owner inputs are ignored.
- hcnt increments on every access and is cleared on every new grant.
- Release by request drop: at an edge in OWN with req[own]=0, no access occurs.
  - If other requests are pending, the next owner is granted at the same edge, with no bubble cycle.
  - Otherwise go to IDLE with gnt=0.
- Release by hold limit: at the edge performing the access that makes hcnt reach MAX_HOLD:
  - If any other req is set, gnt moves to the next round-robin winner, excluding own, at the same edge.
  - If no other req is set, own keeps gnt and hcnt is cleared.
- A grant switch never drops the old owner's access on the hand-over edge; the old owner's final access completes at that edge.
- gnt is always one-hot or zero.
- busy = |gnt, registered with gnt.
- regs_q reflects bank contents directly; a write is visible after its edge.
- Reset asserted mid-burst aborts the grant and clears the bank. After release, arbitration restarts from ptr=0.
- Out-of-range N_REQ/MAX_HOLD values are not supported; guard them with elaboration-time checks.

Decomposition:
- Shared package holds:
  - Width constant DATA_W=8.
  - State encoding IDLE/OWN (1 bit).
  - Helper constant for bank depth.
- One combinational sub-module, rr_pick: inputs req, ptr and an exclude mask; outputs found and a winner index.
- The bank is 2**ADDR_W instances of the team's existing 8-bit async-reset, write-enabled register cell. Each instance's write enable is decoded from own/addr/we.
- The FSM, counters and read register are in the top module.

Test Plan:
- Reset and single write:
  - After reset, check all regs_q=0, gnt=0.
  - req[1]=1, we[1]=1, addr1=3, wdata1=8'hA5.
  - Check: gnt=4'b0010 one cycle later; entry 3 = 8'hA5 after the following edge.
  - Drop req[1]; check gnt=0 next edge.
- Read-back:
  - Requester 2 reads addr 3.
  - Check: rdata=8'hA5, rvalid high for exactly one cycle per read.
- Round-robin fairness:
  - req=4'b1111 held, MAX_HOLD=4.
  - Check grants rotate 0,1,2,3,0, each holding exactly 4 accesses, with no bubble at hand-over.
- Lone owner:
  - Only req[0] held for 20 cycles.
  - Check gnt[0] stays high throughout and 20 accesses occur.
- Early drop:
  - Owner 0 drops req after 2 accesses while req[2]=1.
  - Check gnt moves to 4'b0100 at the same edge, with no idle cycle.
- Reset mid-burst:
  - Assert reset_N=0 during a burst of writes.
  - Check: gnt, rvalid and regs_q clear immediately (asynchronously).
  - After release, with req=4'b0110, check requester 1 is granted first (ptr=0).

Source files
------------

// File: rtl/regbank_arbiter_pkg.sv
// Shared definitions for the register-bank arbiter: data width, FSM states, bank sizing.
package regbank_arbiter_pkg;

    localparam int unsigned DATA_W = 8;

    // Default bank depth for the standard 3-bit address configuration.
    localparam int unsigned BANK_DEPTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    // Number of bank entries for a given address width.
    function automatic int unsigned bank_depth(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/reg8_cell.sv
// 8-bit register cell with asynchronous active-low reset and write enable.
module reg8_cell (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       en,
    input  logic [7:0] d,
    output logic [7:0] q
);

    // Load d when enabled; clear asynchronously on reset.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/regbank_arbiter_rr_pick.sv
// Round-robin selector: first set, non-excluded request bit scanning upward from ptr.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N_REQ-1:0] excl,
    output logic             found,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] cand;

    // Scan ptr, ptr+1, ... wrapping modulo N_REQ; keep the first eligible hit.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[cand] && !excl[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to a shared register bank,
// with a hold limit that forces re-arbitration while others are waiting.
module regbank_arbiter
    import regbank_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                                     clock,
    input  logic                                     reset_N,
    input  logic [N_REQ-1:0]                         req,
    input  logic [N_REQ-1:0]                         we,
    input  logic [N_REQ*ADDR_W-1:0]                  addr,
    input  logic [N_REQ*DATA_W-1:0]                  wdata,
    output logic [N_REQ-1:0]                         gnt,
    output logic [DATA_W-1:0]                        rdata,
    output logic                                     rvalid,
    output logic                                     busy,
    output logic [DATA_W*bank_depth(ADDR_W)-1:0]     regs_q
);

    localparam int unsigned DEPTH  = bank_depth(ADDR_W);
    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned HCNT_W = 4;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("regbank_arbiter: N_REQ must be 2..8");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("regbank_arbiter: MAX_HOLD must be 1..15");
    end

    state_t              state;
    logic [IDX_W-1:0]    own;
    logic [IDX_W-1:0]    ptr;
    logic [HCNT_W-1:0]   hcnt;

    logic [N_REQ-1:0]    excl;
    logic                found;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    winner_next;

    logic                own_req;
    logic                own_we;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;
    logic                access;
    logic                hold_done;
    logic                take_new;

    logic [DEPTH-1:0]    bank_we;
    logic [DATA_W-1:0]   bank_q [DEPTH];

    // Owner's request fields; only the owner's inputs ever reach the bank.
    always_comb begin
        own_req   = req[own];
        own_we    = we[own];
        own_addr  = addr[own*ADDR_W +: ADDR_W];
        own_wdata = wdata[own*DATA_W +: DATA_W];
    end

    // Access, hold-limit and hand-over decisions for the coming edge.
    always_comb begin
        excl = '0;
        if (state == OWN)
            excl[own] = 1'b1;
        access      = (state == OWN) && own_req;
        hold_done   = access && (hcnt == HCNT_W'(MAX_HOLD - 1));
        take_new    = found && ((state == IDLE) || !own_req || hold_done);
        winner_next = (32'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr),
        .excl   (excl),
        .found  (found),
        .winner (winner)
    );

    // Grant FSM: new grant, release to idle, or count another access.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state <= IDLE;
            own   <= '0;
            ptr   <= '0;
            hcnt  <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else if (take_new) begin
            state <= OWN;
            own   <= winner;
            ptr   <= winner_next;
            hcnt  <= '0;
            gnt   <= N_REQ'(1) << winner;
            busy  <= 1'b1;
        end else if ((state == OWN) && !own_req) begin
            state <= IDLE;
            hcnt  <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else if (access) begin
            hcnt  <= hold_done ? '0 : hcnt + 1'b1;
        end
    end

    // Read port: capture the owner's read and pulse rvalid for one cycle.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= access && !own_we;
            if (access && !own_we)
                rdata <= bank_q[own_addr];
        end
    end

    // Decode the owner's write into a single entry enable.
    always_comb begin
        bank_we = '0;
        if (access && own_we)
            bank_we[own_addr] = 1'b1;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_bank
        reg8_cell u_cell (
            .clock   (clock),
            .reset_N (reset_N),
            .en      (bank_we[k]),
            .d       (own_wdata),
            .q       (bank_q[k])
        );
        assign regs_q[k*DATA_W +: DATA_W] = bank_q[k];
    end

endmodule
